// File: rtl/iir_output_buffer.sv
// IIR output stage: signed fixed-point gain with saturation, FWFT FIFO,
// valid/ready drain and sticky drop/clip status.
module iir_output_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int GAIN_FRAC_BITS = 10,
    parameter int DEPTH          = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [DATA_WIDTH-1:0]  filteredData,
    input  logic                          done,
    input  logic signed [DATA_WIDTH-1:0]  gain,
    input  logic                          clearStatus,
    output logic [DATA_WIDTH-1:0]         outData,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [$clog2(DEPTH):0]        fillLevel,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          dropCount,
    output logic [CNT_WIDTH-1:0]          satCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] MAXV =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV =
        {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                  r_s1_valid;
    logic signed [PW-1:0]  r_s1_prod;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic [CNT_WIDTH-1:0]  r_sat_cnt;

    logic signed [PW-1:0]  w_fd_ext;
    logic signed [PW-1:0]  w_gain_ext;
    logic signed [PW-1:0]  w_shift;
    logic                  w_hi;
    logic                  w_lo;
    logic                  w_clip;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_accept;
    logic                  w_drop;

    assign w_fd_ext   = PW'(filteredData);
    assign w_gain_ext = PW'(gain);

    // Arithmetic shift floors toward -inf before the clamp.
    assign w_shift = r_s1_prod >>> GAIN_FRAC_BITS;
    assign w_hi    = w_shift > MAXV;
    assign w_lo    = w_shift < MINV;
    assign w_clip  = r_s1_valid && (w_hi || w_lo);
    assign w_wdata = w_hi ? MAXV[DATA_WIDTH-1:0] :
                     w_lo ? MINV[DATA_WIDTH-1:0] :
                            w_shift[DATA_WIDTH-1:0];

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop on the same edge frees the slot for a write into a full FIFO.
    assign w_rd     = !w_empty && outReady;
    assign w_accept = r_s1_valid && (!w_full || w_rd);
    assign w_drop   = r_s1_valid && w_full && !w_rd;

    assign outValid  = !w_empty;
    assign outData   = r_mem[r_rd_ptr[AW-1:0]];
    assign fillLevel = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign dropCount = r_drop_cnt;
    assign satCount  = r_sat_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_s1_valid <= done;
            if (done) begin
                r_s1_prod <= w_fd_ext * w_gain_ext;
            end
            if (w_accept) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Clear wins over accumulated history but not over this edge's event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_sat_cnt  <= '0;
        end else if (clearStatus) begin
            r_overflow <= w_drop;
            r_drop_cnt <= w_drop ? CNT_WIDTH'(1) : '0;
            r_sat_cnt  <= w_clip ? CNT_WIDTH'(1) : '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                end
            end
            if (w_clip && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
